// File: rtl/trap_pkg.sv
// Shared constants for the user-mode trap controller: CSR addresses, status bit positions,
// cause codes and the sequencer state encoding.
package trap_pkg;

    localparam logic [11:0] CsrUstatus  = 12'h000;
    localparam logic [11:0] CsrUie      = 12'h004;
    localparam logic [11:0] CsrUtvec    = 12'h005;
    localparam logic [11:0] CsrUscratch = 12'h040;
    localparam logic [11:0] CsrUepc     = 12'h041;
    localparam logic [11:0] CsrUcause   = 12'h042;
    localparam logic [11:0] CsrUip      = 12'h044;

    localparam int unsigned UstatusUie  = 0;
    localparam int unsigned UstatusUpie = 4;
    localparam int unsigned UieUeie     = 8;
    localparam int unsigned UipUeip     = 8;

    localparam logic [31:0] CauseIllegal = 32'd2;
    localparam logic [31:0] CauseBreak   = 32'd3;
    localparam logic [31:0] CauseEcallU  = 32'd8;
    localparam logic [31:0] CauseUextIrq = 32'h8000_0008;

    typedef enum logic [1:0] {
        StIdle,
        StEnter,
        StReturn
    } trap_state_e;

    // op is funct3[1:0]: 01 RW, 10 RS, 11 RC
    function automatic logic [31:0] csr_apply(input logic [1:0] op, input logic [31:0] old_val,
                                              input logic [31:0] src);
        logic [31:0] res;
        unique case (op)
            2'b01:   res = src;
            2'b10:   res = old_val | src;
            2'b11:   res = old_val & ~src;
            default: res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_file.sv
// User-mode trap CSR storage: read mux, Zicsr RW/RS/RC update and trap entry/return capture.
// The UEIE/UEIP bits exist only when TRAP_IRQ_EN is defined.
module csr_file
    import trap_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [11:0] addr_i,
    output logic [31:0] rdata_o,
    input  logic        wr_en_i,
    input  logic [2:0]  funct3_i,
    input  logic [4:0]  rs1_i,
    input  logic [31:0] rs1_data_i,
    input  logic        ext_irq_i,
    input  logic        trap_enter_i,
    input  logic        trap_irq_i,
    input  logic [31:0] trap_pc_i,
    input  logic [31:0] trap_cause_i,
    input  logic        trap_ret_i,
    output logic        uie_o,
    output logic        ueie_o,
    output logic [31:0] utvec_o,
    output logic [31:0] uepc_o
);

    logic        uie_q, uie_d;
    logic        upie_q, upie_d;
    logic        ueie_q, ueie_d;
    logic [31:0] utvec_q, utvec_d;
    logic [31:0] uscratch_q, uscratch_d;
    logic [31:0] uepc_q, uepc_d;
    logic [31:0] ucause_q, ucause_d;

    logic [31:0] src;
    logic [31:0] new_val;
    logic        do_write;
    logic        ueip;

`ifdef TRAP_IRQ_EN
    assign ueip = ext_irq_i;
`else
    logic unused_ext_irq;
    assign unused_ext_irq = ext_irq_i;
    assign ueip = 1'b0;
`endif

    always_comb begin
        rdata_o = 32'h0;
        unique case (addr_i)
            CsrUstatus: begin
                rdata_o[UstatusUie]  = uie_q;
                rdata_o[UstatusUpie] = upie_q;
            end
            CsrUie:      rdata_o[UieUeie] = ueie_q;
            CsrUtvec:    rdata_o = utvec_q;
            CsrUscratch: rdata_o = uscratch_q;
            CsrUepc:     rdata_o = uepc_q;
            CsrUcause:   rdata_o = ucause_q;
            CsrUip:      rdata_o[UipUeip] = ueip;
            default:     rdata_o = 32'h0;
        endcase
    end

    // funct3[2] selects the zero-extended immediate; RS/RC with rs1==0 are pure reads
    assign src      = funct3_i[2] ? {27'h0, rs1_i} : rs1_data_i;
    assign new_val  = csr_apply(funct3_i[1:0], rdata_o, src);
    assign do_write = wr_en_i && (funct3_i[1:0] != 2'b00) && !(funct3_i[1] && (rs1_i == 5'd0));

    always_comb begin
        uie_d      = uie_q;
        upie_d     = upie_q;
        ueie_d     = ueie_q;
        utvec_d    = utvec_q;
        uscratch_d = uscratch_q;
        uepc_d     = uepc_q;
        ucause_d   = ucause_q;
        if (trap_enter_i) begin
            uepc_d   = trap_pc_i & ~32'd1;
            ucause_d = trap_irq_i ? CauseUextIrq : trap_cause_i;
            upie_d   = uie_q;
            uie_d    = 1'b0;
        end else if (trap_ret_i) begin
            uie_d  = upie_q;
            upie_d = 1'b1;
        end else if (do_write) begin
            unique case (addr_i)
                CsrUstatus: begin
                    uie_d  = new_val[UstatusUie];
                    upie_d = new_val[UstatusUpie];
                end
`ifdef TRAP_IRQ_EN
                CsrUie:      ueie_d = new_val[UieUeie];
`endif
                CsrUtvec:    utvec_d    = new_val & ~32'd3;
                CsrUscratch: uscratch_d = new_val;
                CsrUepc:     uepc_d     = new_val & ~32'd1;
                CsrUcause:   ucause_d   = new_val;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            uie_q      <= 1'b0;
            upie_q     <= 1'b0;
            ueie_q     <= 1'b0;
            utvec_q    <= 32'h0;
            uscratch_q <= 32'h0;
            uepc_q     <= 32'h0;
            ucause_q   <= 32'h0;
        end else begin
            uie_q      <= uie_d;
            upie_q     <= upie_d;
            ueie_q     <= ueie_d;
            utvec_q    <= utvec_d;
            uscratch_q <= uscratch_d;
            uepc_q     <= uepc_d;
            ucause_q   <= ucause_d;
        end
    end

    assign uie_o   = uie_q;
    assign ueie_o  = ueie_q;
    assign utvec_o = utvec_q;
    assign uepc_o  = uepc_q;

endmodule

// File: rtl/trap_ctrl.sv
// Trap entry/return sequencer for the single-cycle RV32 core; owns the user trap CSRs.
// Define TRAP_IRQ_EN to include the external-interrupt path (UEIE/UEIP, irq_ack).
module trap_ctrl
    import trap_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] pc,
    input  logic        exception,
    input  logic [31:0] cause,
    input  logic        uret,
    input  logic        csr,
    input  logic [2:0]  funct3,
    input  logic [11:0] csr_addr,
    input  logic [4:0]  rs1,
    input  logic [31:0] rs1_data,
    input  logic        ext_irq,
    output logic        irq_ack,
    output logic [31:0] csr_rdata,
    output logic        stall,
    output logic        redirect,
    output logic [31:0] trap_pc
);

    trap_state_e state_q;
    logic        redirect_q;
    logic        irq_ack_q;
    logic [31:0] trap_pc_q;

    logic        uie, ueie;
    logic [31:0] utvec, uepc;
    logic        live, irq_take, enter, ret, csr_we;

    assign live = (state_q == StIdle) && instr_valid && !rst;

`ifdef TRAP_IRQ_EN
    assign irq_take = live && uie && ueie && ext_irq;
`else
    logic unused_irq;
    assign unused_irq = ueie;
    assign irq_take   = 1'b0;
`endif

    assign enter  = live && (irq_take || exception);
    assign ret    = live && !enter && uret;
    assign csr_we = live && csr && !enter && !ret;
    // Held through the whole two-cycle sequence; the detection cycle is combinational
    assign stall  = !rst && ((state_q != StIdle) || enter || ret);

    csr_file u_csr_file (
        .clk_i        (clk),
        .rst_i        (rst),
        .addr_i       (csr_addr),
        .rdata_o      (csr_rdata),
        .wr_en_i      (csr_we),
        .funct3_i     (funct3),
        .rs1_i        (rs1),
        .rs1_data_i   (rs1_data),
        .ext_irq_i    (ext_irq),
        .trap_enter_i (enter),
        .trap_irq_i   (irq_take),
        .trap_pc_i    (pc),
        .trap_cause_i (cause),
        .trap_ret_i   (ret),
        .uie_o        (uie),
        .ueie_o       (ueie),
        .utvec_o      (utvec),
        .uepc_o       (uepc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            redirect_q <= 1'b0;
            irq_ack_q  <= 1'b0;
            trap_pc_q  <= 32'h0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (enter) begin
                        state_q    <= StEnter;
                        redirect_q <= 1'b1;
                        irq_ack_q  <= irq_take;
                        trap_pc_q  <= utvec;
                    end else if (ret) begin
                        state_q    <= StReturn;
                        redirect_q <= 1'b1;
                        irq_ack_q  <= 1'b0;
                        trap_pc_q  <= uepc;
                    end else begin
                        redirect_q <= 1'b0;
                        irq_ack_q  <= 1'b0;
                    end
                end
                StEnter, StReturn: begin
                    state_q    <= StIdle;
                    redirect_q <= 1'b0;
                    irq_ack_q  <= 1'b0;
                end
                default: begin
                    state_q    <= StIdle;
                    redirect_q <= 1'b0;
                    irq_ack_q  <= 1'b0;
                end
            endcase
        end
    end

    assign redirect = redirect_q;
    assign irq_ack  = irq_ack_q;
    assign trap_pc  = trap_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: directed trap/CSR scenarios followed by random traffic,
// checked against an architectural model of the user trap CSRs.
module tb_trap_ctrl;

`ifdef TRAP_IRQ_EN
    localparam bit IrqEn = 1'b1;
`else
    localparam bit IrqEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, instr_valid, exception, uret, csr, ext_irq;
    logic [31:0] pc, cause, rs1_data;
    logic [2:0]  funct3;
    logic [11:0] csr_addr;
    logic [4:0]  rs1;
    logic        irq_ack, stall, redirect;
    logic [31:0] csr_rdata, trap_pc;

    always #5 clk = ~clk;

    trap_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .pc          (pc),
        .exception   (exception),
        .cause       (cause),
        .uret        (uret),
        .csr         (csr),
        .funct3      (funct3),
        .csr_addr    (csr_addr),
        .rs1         (rs1),
        .rs1_data    (rs1_data),
        .ext_irq     (ext_irq),
        .irq_ack     (irq_ack),
        .csr_rdata   (csr_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .trap_pc     (trap_pc)
    );

    typedef struct packed {
        logic        stall;
        logic        redirect;
        logic [31:0] rdata;
    } exp_t;

    exp_t        cq[$];
    logic [32:0] rq[$];
    int          n_vec = 0;
    int          n_err = 0;

    // Architectural model state
    logic        m_uie, m_upie, m_ueie, m_busy;
    logic [31:0] m_utvec, m_uscratch, m_uepc, m_ucause;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void m_reset();
        m_uie = 0; m_upie = 0; m_ueie = 0; m_busy = 0;
        m_utvec = 0; m_uscratch = 0; m_uepc = 0; m_ucause = 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a, input logic irq);
        case (a)
            12'h000: return (m_upie ? 32'h10 : 32'h0) | (m_uie ? 32'h1 : 32'h0);
            12'h004: return (IrqEn && m_ueie) ? 32'h100 : 32'h0;
            12'h005: return m_utvec;
            12'h040: return m_uscratch;
            12'h041: return m_uepc;
            12'h042: return m_ucause;
            12'h044: return (IrqEn && irq) ? 32'h100 : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    function automatic void m_write(input logic [11:0] a, input logic [31:0] v);
        case (a)
            12'h000: begin m_uie = v[0]; m_upie = v[4]; end
            12'h004: if (IrqEn) m_ueie = v[8];
            12'h005: m_utvec = {v[31:2], 2'b00};
            12'h040: m_uscratch = v;
            12'h041: m_uepc = {v[31:1], 1'b0};
            12'h042: m_ucause = v;
            default: ;
        endcase
    endfunction

    // Predict this cycle's outputs, advance the model, then let the clock edge happen
    task automatic step();
        exp_t        e;
        logic        irq;
        logic [31:0] src, oldv, nv;
        logic        wr;
        e.redirect = m_busy;
        e.rdata    = m_read(csr_addr, ext_irq);
        e.stall    = 1'b0;
        if (rst) begin
            m_reset();
        end else if (m_busy) begin
            e.stall = 1'b1;
            m_busy  = 1'b0;
        end else if (instr_valid) begin
            irq = IrqEn && m_uie && m_ueie && ext_irq;
            if (irq || exception) begin
                rq.push_back({m_utvec, irq});
                m_uepc   = {pc[31:1], 1'b0};
                m_ucause = irq ? 32'h8000_0008 : cause;
                m_upie   = m_uie;
                m_uie    = 1'b0;
                m_busy   = 1'b1;
                e.stall  = 1'b1;
            end else if (uret) begin
                rq.push_back({m_uepc, 1'b0});
                m_uie   = m_upie;
                m_upie  = 1'b1;
                m_busy  = 1'b1;
                e.stall = 1'b1;
            end else if (csr) begin
                src  = funct3[2] ? {27'h0, rs1} : rs1_data;
                oldv = e.rdata;
                wr   = 1'b0;
                nv   = oldv;
                case (funct3[1:0])
                    2'b01: begin nv = src; wr = 1'b1; end
                    2'b10: begin nv = oldv | src; wr = (rs1 != 0); end
                    2'b11: begin nv = oldv & ~src; wr = (rs1 != 0); end
                    default: ;
                endcase
                if (wr) m_write(csr_addr, nv);
            end
        end
        cq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        rst = 0; instr_valid = 1; exception = 0; uret = 0; csr = 0; ext_irq = 0;
        pc = 32'h200; cause = 0; funct3 = 0; csr_addr = 12'hfff; rs1 = 0; rs1_data = 0;
    endtask

    task automatic csr_op(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r,
                          input logic [31:0] d);
        quiet();
        csr = 1; funct3 = f3; csr_addr = a; rs1 = r; rs1_data = d;
        step();
    endtask

    task automatic trap(input logic exc, input logic [31:0] c, input logic [31:0] p,
                        input logic irq);
        quiet();
        exception = exc; cause = c; pc = p; ext_irq = irq;
        step();
        // Decoder strobes during the busy cycle must be ignored
        quiet();
        exception = 1; uret = 1; csr = 1; funct3 = 3'b001; csr_addr = 12'h040;
        rs1 = 1; rs1_data = 32'h5555_5555;
        step();
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [32:0] r;
        if (cq.size() > 0) begin
            e = cq.pop_front();
            chk("stall", {31'h0, stall}, {31'h0, e.stall});
            chk("redirect", {31'h0, redirect}, {31'h0, e.redirect});
            chk("csr_rdata", csr_rdata, e.rdata);
            if (e.redirect) begin
                if (rq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL redirect_queue: got empty expected entry at %0t", $time);
                end else begin
                    r = rq.pop_front();
                    chk("trap_pc", trap_pc, r[32:1]);
                    chk("irq_ack", {31'h0, irq_ack}, {31'h0, r[0]});
                end
            end else begin
                chk("irq_ack_idle", {31'h0, irq_ack}, 32'h0);
            end
        end
    end

    initial begin
        logic [11:0] addrs[8];
        logic [31:0] causes[3];
        addrs  = '{12'h000, 12'h004, 12'h005, 12'h040, 12'h041, 12'h042, 12'h044, 12'h123};
        causes = '{32'd2, 32'd3, 32'd8};
        m_reset();
        quiet();
        rst = 1;
        @(posedge clk);
        #1;
        step();
        quiet();

        // utvec write with low bits set, then read back
        csr_op(3'b001, 12'h005, 5'd1, 32'h0000_0103);
        csr_op(3'b010, 12'h005, 5'd0, 32'hffff_ffff);
        // UIE=UPIE=1, then ecall and uret
        csr_op(3'b001, 12'h000, 5'd2, 32'h0000_0011);
        trap(1'b1, 32'd8, 32'h40, 1'b0);
        csr_op(3'b010, 12'h041, 5'd0, 32'h0);
        csr_op(3'b010, 12'h042, 5'd0, 32'h0);
        quiet(); uret = 1; step();
        quiet(); step();
        csr_op(3'b010, 12'h000, 5'd0, 32'h0);
        // Interrupt beats a simultaneous illegal instruction
        csr_op(3'b101, 12'h000, 5'd1, 32'h0);
        csr_op(3'b001, 12'h004, 5'd3, 32'h0000_0100);
        quiet(); ext_irq = 1; csr = 1; funct3 = 3'b010; csr_addr = 12'h044; step();
        trap(1'b1, 32'd2, 32'h80, 1'b1);
        csr_op(3'b010, 12'h042, 5'd0, 32'h0);
        csr_op(3'b010, 12'h041, 5'd0, 32'h0);
        csr_op(3'b010, 12'h000, 5'd0, 32'h0);
        // RS with rs1==0 must not write
        csr_op(3'b001, 12'h040, 5'd4, 32'hdead_beef);
        csr_op(3'b010, 12'h040, 5'd0, 32'h0000_00ff);
        csr_op(3'b011, 12'h040, 5'd0, 32'hffff_ffff);
        csr_op(3'b010, 12'h040, 5'd0, 32'h0);
        // Reset while in ENTER
        quiet(); exception = 1; cause = 32'd3; pc = 32'h44; step();
        quiet(); rst = 1; step();
        quiet(); step();
        for (int i = 0; i < 8; i++) csr_op(3'b010, addrs[i], 5'd0, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 99) == 0);
            instr_valid = ($urandom_range(0, 7) != 0);
            exception   = ($urandom_range(0, 11) == 0);
            uret        = ($urandom_range(0, 11) == 0);
            csr         = $urandom_range(0, 1) == 1;
            funct3      = 3'($urandom_range(0, 7));
            csr_addr    = addrs[$urandom_range(0, 7)];
            rs1         = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rs1_data    = $urandom;
            cause       = causes[$urandom_range(0, 2)];
            ext_irq     = ($urandom_range(0, 3) == 0);
            pc          = $urandom;
            step();
        end
        quiet();
        step();
        step();
        @(negedge clk);
        #1;
        chk("queue_drained", cq.size(), 32'h0);
        chk("redirect_queue_drained", rq.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
